// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths, function codes and reservation-station entry layout.
package tomasulo_pkg;
  localparam int TAG_W_DEF = 3;
  localparam int DATA_W_DEF = 32;
  localparam int AGE_W = 2;
  localparam logic [2:0] FUN3_MUL = 3'd0;
  localparam logic [2:0] FUN3_DIV = 3'd1;
  typedef struct packed {
    logic valid;
    logic [2:0] fun3;
    logic [TAG_W_DEF-1:0] des;
    logic [TAG_W_DEF-1:0] q1;
    logic [TAG_W_DEF-1:0] q2;
    logic [DATA_W_DEF-1:0] v1;
    logic [DATA_W_DEF-1:0] v2;
    logic r1;
    logic r2;
    logic [AGE_W-1:0] age;
  } rs_entry_t;
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: one-hot grant of the ready entry with the smallest age rank.
module rs_age_select import tomasulo_pkg::*; #(
  parameter int N = 3
) (
  input  logic [N-1:0]            req,
  input  logic [N-1:0][AGE_W-1:0] age,
  output logic [N-1:0]            grant,
  output logic                    grant_valid
);
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < N; j++)
        if (j != i && req[j] && age[j] < age[i]) grant[i] = 1'b0;
    end
  end
  assign grant_valid = |req;
endmodule

// File: rtl/mul_rs_issue.sv
// mul_rs_issue: mul/div reservation station with CDB snoop and oldest-ready dispatch.
module mul_rs_issue import tomasulo_pkg::*; #(
  parameter int ENTRIES = 3,
  parameter int TAG_W = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        issue_fun3,
  input  logic [TAG_W-1:0]  issue_des,
  input  logic [DATA_W-1:0] issue_v1,
  input  logic [DATA_W-1:0] issue_v2,
  input  logic [TAG_W-1:0]  issue_q1,
  input  logic [TAG_W-1:0]  issue_q2,
  input  logic              issue_rdy1,
  input  logic              issue_rdy2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              exe_done,
  output logic              fla,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [TAG_W-1:0]  des,
  output logic [2:0]        fun3,
  output logic [1:0]        mul_rs_c
);
  localparam logic [1:0] FULL = 2'(ENTRIES);
  rs_entry_t rs [ENTRIES];
  rs_entry_t fresh;
  logic unit_busy, do_issue, can_disp, grant_valid, found;
  logic [ENTRIES-1:0] req, grant, free_oh;
  logic [ENTRIES-1:0][AGE_W-1:0] ages;
  logic [AGE_W-1:0] new_age, sel_age;
  logic [DATA_W-1:0] sel_v1, sel_v2;
  logic [TAG_W-1:0] sel_des;
  logic [2:0] sel_fun3;
  assign issue_ready = mul_rs_c < FULL;
  assign do_issue = issue_valid && issue_ready;
  assign can_disp = grant_valid && (!unit_busy || exe_done);
  // Age is a rank among survivors, so a newcomer ranks behind everything not leaving this edge.
  assign new_age = mul_rs_c - {1'b0, can_disp};
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      req[i] = rs[i].valid && rs[i].r1 && rs[i].r2;
      ages[i] = rs[i].age;
    end
  end
  rs_age_select #(.N(ENTRIES)) u_sel (
    .req(req),
    .age(ages),
    .grant(grant),
    .grant_valid(grant_valid)
  );
  always_comb begin
    sel_v1 = '0;
    sel_v2 = '0;
    sel_des = '0;
    sel_fun3 = '0;
    sel_age = '0;
    free_oh = '0;
    found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant[i]) begin
        sel_v1 = rs[i].v1;
        sel_v2 = rs[i].v2;
        sel_des = rs[i].des;
        sel_fun3 = rs[i].fun3;
        sel_age = rs[i].age;
      end
      if (!rs[i].valid && !found) begin
        free_oh[i] = 1'b1;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    fresh = '0;
    fresh.valid = 1'b1;
    fresh.fun3 = issue_fun3;
    fresh.des = issue_des;
    fresh.age = new_age;
    fresh.q1 = issue_q1;
    fresh.q2 = issue_q2;
    fresh.r1 = issue_rdy1 || (cdb_valid && cdb_tag == issue_q1);
    fresh.r2 = issue_rdy2 || (cdb_valid && cdb_tag == issue_q2);
    fresh.v1 = issue_rdy1 ? issue_v1 : cdb_data;
    fresh.v2 = issue_rdy2 ? issue_v2 : cdb_data;
  end
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) rs[i] <= '0;
      unit_busy <= 1'b0;
      fla <= 1'b0;
      data1 <= '0;
      data2 <= '0;
      des <= '0;
      fun3 <= '0;
      mul_rs_c <= '0;
    end else begin
      fla <= can_disp;
      if (can_disp) begin
        data1 <= sel_v1;
        data2 <= sel_v2;
        des <= sel_des;
        fun3 <= sel_fun3;
      end
      unit_busy <= can_disp || (unit_busy && !exe_done);
      mul_rs_c <= mul_rs_c + {1'b0, do_issue} - {1'b0, can_disp};
      for (int i = 0; i < ENTRIES; i++) begin
        if (do_issue && free_oh[i]) rs[i] <= fresh;
        else if (can_disp && grant[i]) rs[i].valid <= 1'b0;
        else if (rs[i].valid) begin
          if (cdb_valid && !rs[i].r1 && rs[i].q1 == cdb_tag) begin
            rs[i].v1 <= cdb_data;
            rs[i].r1 <= 1'b1;
          end
          if (cdb_valid && !rs[i].r2 && rs[i].q2 == cdb_tag) begin
            rs[i].v2 <= cdb_data;
            rs[i].r2 <= 1'b1;
          end
          if (can_disp && rs[i].age > sel_age) rs[i].age <= rs[i].age - AGE_W'(1);
        end
      end
    end
  end
endmodule
